d_input_conditioner: RTL and testbench
======================================

// Module: d_input_conditioner
// PURPOSE
//  Upstream stage for the latch/flop storage cells: it conditions a raw asynchronous input into a
//  clean data bit (d_out) plus a one-cycle load strobe (en_out), and these drive the storage
//  cell's d/en pins.
//  - Flow: raw input -> synchronizer chain -> debounce FSM -> registered d_out.
//  - rise/fall strobes on each accepted change.
//  - en_in freezes the debounce decision without stopping the synchronizer.
// PARAMETERS
//  SYNC_STAGES      2  synchronizer flops (>=2)
//  DEBOUNCE_CYCLES  4  consecutive agreeing samples required after first mismatch (>=1)
//  CNT_W            $clog2(DEBOUNCE_CYCLES+1)  counter width (derived, not overridden)
// PORTS
//  clk      in   1  single clock, all state on posedge
//  reset    in   1  synchronous, active-low (0 = reset, sampled on posedge clk)
//  din      in   1  raw asynchronous input
//  en_in    in   1  1 = debounce FSM may advance/commit; 0 = FSM frozen
//  d_out    out  1  debounced, registered level (feeds storage cell d)
//  en_out   out  1  1-cycle strobe in the cycle d_out takes a new value (feeds storage cell en)
//  rise     out  1  1-cycle strobe, accepted 0->1 change (coincident with en_out)
//  fall     out  1  1-cycle strobe, accepted 1->0 change (coincident with en_out)
//  stable   out  1  1 when FSM in IDLE (no pending candidate)
// BEHAVIOUR
//  - Reset (reset==0 at posedge):
//    - sync chain, d_out, en_out, rise, fall, cnt and cand all <= 0.
//    - state <= IDLE, so stable = 1.
//    - Reset has priority over everything, including en_in.
//    - A pending candidate is discarded and no strobe is issued.
//  - Sync chain: shifts din every cycle, independent of en_in.
//    - s = last stage; din is visible on s after SYNC_STAGES edges.
//  - FSM states: IDLE, COUNT. Registers: cand (1b), cnt (CNT_W).
//  - IDLE, en_in=1:
//    - s!=d_out: cand<=s, cnt<=1, go COUNT.
//    - else stay.
//  - COUNT, en_in=1:
//    - s!=cand (glitch ended): cnt<=0, go IDLE, d_out unchanged.
//    - s==cand and cnt<DEBOUNCE_CYCLES: cnt<=cnt+1.
//    - s==cand and cnt==DEBOUNCE_CYCLES: commit.
//      - d_out<=cand, en_out<=1.
//      - rise<=cand, fall<=~cand.
//      - cnt<=0, go IDLE.
//  - en_in=0: state, cnt, cand and d_out hold.
//    - en_out, rise and fall are 0 next cycle.
//    - If en_in drops on the would-be commit cycle, there is no commit; the commit happens on the
//      first later en_in=1 cycle where s==cand still holds.
//  - Strobes: registered, exactly one cycle wide. They are never asserted in consecutive cycles
//    because each commit returns to IDLE.
//  - Latency (en_in=1 throughout): din step to d_out/en_out = SYNC_STAGES+DEBOUNCE_CYCLES+1 edges
//    (7 at defaults).
//  - Pulse rejection: a din pulse whose s-level lasts <=DEBOUNCE_CYCLES cycles never reaches d_out.
//  - cnt never exceeds DEBOUNCE_CYCLES; no wrap-around.
//  - stable = (state==IDLE), combinational from the state register.
// TESTING
//  1. Hold reset=0 for 3 clk with din=1 -> d_out=0, strobes=0, stable=1 throughout.
//     Release -> d_out=1 and rise=1 exactly 7 edges later.
//  2. Clean din 0->1 at defaults -> en_out=rise=1 for one cycle on edge 7, d_out=1 thereafter.
//     Then 1->0 -> fall=1 on edge 7.
//  3. din high for 3 cycles, then low (glitch) -> stable=0 briefly, returns to 1.
//     d_out stays 0, no en_out.
//     Repeat with 5 cycles -> accepted.
//  4. en_in=0 on the commit cycle of a 0->1 change, held 3 cycles -> no strobe while low.
//     en_in=1 -> commit next edge, rise=1.
//  5. reset=0 asserted while in COUNT (cnt=2) -> next edge cnt=0, IDLE, d_out=0, no strobe.
//  6. Sweep SYNC_STAGES=3, DEBOUNCE_CYCLES=1 -> step latency 5 edges.
//     1-cycle s pulse rejected, 2-cycle s pulse accepted.

Source files
------------

// File: rtl/d_input_conditioner.sv
// rtl/d_input_conditioner.sv - synchronizer plus debounce FSM producing a clean level and load strobes
`timescale 1ns/1ps

module d_input_conditioner #(
  parameter int  SYNC_STAGES     = 2,
  parameter int  DEBOUNCE_CYCLES = 4,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  input  logic en_in,
  output logic d_out,
  output logic en_out,
  output logic rise,
  output logic fall,
  output logic stable
);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   cand_q, cand_d;
  logic                   d_out_q, d_out_d;
  logic                   en_out_q, en_out_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  assign s = sync_q[SYNC_STAGES-1];

  // Synchronizer chain: shifts every cycle regardless of en_in so the sampled
  // level is always current when the FSM is released.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  // Debounce state and registered outputs; reset drops any pending candidate.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cand_q   <= 1'b0;
      d_out_q  <= 1'b0;
      en_out_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cand_q   <= cand_d;
      d_out_q  <= d_out_d;
      en_out_q <= en_out_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  // Next-state logic: a candidate must be seen on DEBOUNCE_CYCLES further
  // samples before it is committed; en_in low freezes everything but strobes.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cand_d   = cand_q;
    d_out_d  = d_out_q;
    en_out_d = 1'b0;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (en_in) begin
      unique case (state_q)
        IDLE: begin
          if (s != d_out_q) begin
            cand_d  = s;
            cnt_d   = CNT_ONE;
            state_d = COUNT;
          end
        end
        COUNT: begin
          if (s != cand_q) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
          end else begin
            d_out_d  = cand_q;
            en_out_d = 1'b1;
            rise_d   = cand_q;
            fall_d   = ~cand_q;
            cnt_d    = '0;
            state_d  = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign d_out  = d_out_q;
  assign en_out = en_out_q;
  assign rise   = rise_q;
  assign fall   = fall_q;
  assign stable = (state_q == IDLE);

endmodule

// File: tb/tb_d_input_conditioner.sv
// tb/tb_d_input_conditioner.sv - directed self-checking bench for d_input_conditioner
`timescale 1ns/1ps

module tb_d_input_conditioner;

  logic clk = 1'b0;
  logic reset, din, en_in, din2;
  logic d_out, en_out, rise, fall, stable;
  logic d_out2, en_out2, rise2, fall2, stable2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  d_input_conditioner dut (
    .clk(clk), .reset(reset), .din(din), .en_in(en_in),
    .d_out(d_out), .en_out(en_out), .rise(rise), .fall(fall), .stable(stable)
  );

  d_input_conditioner #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(1)) dut2 (
    .clk(clk), .reset(reset), .din(din2), .en_in(en_in),
    .d_out(d_out2), .en_out(en_out2), .rise(rise2), .fall(fall2), .stable(stable2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic d, input logic e,
                         input logic r, input logic f, input logic st);
    chk({tag, ".d_out"}, d_out, d);
    chk({tag, ".en_out"}, en_out, e);
    chk({tag, ".rise"}, rise, r);
    chk({tag, ".fall"}, fall, f);
    chk({tag, ".stable"}, stable, st);
  endtask

  task automatic chk_all2(input string tag, input logic d, input logic e,
                          input logic r, input logic f, input logic st);
    chk({tag, ".d_out"}, d_out2, d);
    chk({tag, ".en_out"}, en_out2, e);
    chk({tag, ".rise"}, rise2, r);
    chk({tag, ".fall"}, fall2, f);
    chk({tag, ".stable"}, stable2, st);
  endtask

  // Clean step to newv from a settled opposite level: commit on edge 7.
  task automatic step_change(input string tag, input logic newv);
    din = newv;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk_all($sformatf("%s_lat%0d", tag, i), ~newv, 1'b0, 1'b0, 1'b0, (i < 3));
    end
    tick();
    chk_all({tag, "_commit"}, newv, 1'b1, newv, ~newv, 1'b1);
  endtask

  initial begin
    reset = 1'b0;
    din   = 1'b1;
    din2  = 1'b0;
    en_in = 1'b1;

    // 1: reset held with din high, then release -> rise 7 edges later
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all("t1_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    reset = 1'b1;
    step_change("t1_rel", 1'b1);
    tick();
    chk_all("t1_hold", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // 2: clean falling then rising then falling steps
    step_change("t2_fall", 1'b0);
    step_change("t2_rise", 1'b1);
    tick();
    chk_all("t2_hold", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step_change("t2_fall2", 1'b0);

    // 3a: 3-cycle high glitch is rejected
    din = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk_all($sformatf("t3_gl%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, (i < 3));
    end
    din = 1'b0;
    for (int i = 4; i <= 10; i++) begin
      tick();
      chk_all($sformatf("t3_gl%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, (i > 5));
    end

    // 3b: 5-cycle high pulse is accepted, then its falling edge commits too
    din = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk_all($sformatf("t3_p%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, (i < 3));
    end
    din = 1'b0;
    tick();
    chk_all("t3_p6", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_all("t3_p7_rise", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 8; i <= 11; i++) begin
      tick();
      chk_all($sformatf("t3_p%0d", i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    tick();
    chk_all("t3_p12_fall", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    chk_all("t3_p13", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // 4: en_in low over the would-be commit edge delays the commit
    din = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk_all($sformatf("t4_lat%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, (i < 3));
    end
    en_in = 1'b0;
    for (int i = 7; i <= 9; i++) begin
      tick();
      chk_all($sformatf("t4_frz%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    en_in = 1'b1;
    tick();
    chk_all("t4_commit", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    step_change("t4_back", 1'b0);

    // 5: reset in COUNT with cnt=2 discards the candidate
    din = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk_all($sformatf("t5_lat%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, (i < 3));
    end
    reset = 1'b0;
    tick();
    chk_all("t5_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    step_change("t5_rel", 1'b1);
    step_change("t5_back", 1'b0);

    // 6: SYNC_STAGES=3, DEBOUNCE_CYCLES=1 instance
    din2 = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk_all2($sformatf("t6_lat%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, (i < 4));
    end
    tick();
    chk_all2("t6_rise", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    chk_all2("t6_hold", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    din2 = 1'b0;
    tick();
    din2 = 1'b1;
    for (int i = 2; i <= 8; i++) begin
      tick();
      chk_all2($sformatf("t6_p1_%0d", i), 1'b1, 1'b0, 1'b0, 1'b0, (i != 4));
    end

    din2 = 1'b0;
    tick();
    chk_all2("t6_p2_1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    din2 = 1'b1;
    chk_all2("t6_p2_2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_all2("t6_p2_3", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_all2("t6_p2_4", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_all2("t6_p2_5_fall", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    chk_all2("t6_p2_6", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_all2("t6_p2_7_rise", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    chk_all2("t6_p2_8", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t6_dut1_quiet", d_out, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
